// File: rtl/rc5_stream_ctrl_if.sv
// Stream bundle for rc5_stream_ctrl: input block channel (s_*) and result channel (m_*).
interface rc5_stream_ctrl_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_decrypt;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    // Upstream/downstream side: produces blocks, consumes results.
    modport master (
        output s_valid, s_data, s_decrypt, m_ready,
        input  s_ready, m_valid, m_data
    );

    // Controller side.
    modport slave (
        input  s_valid, s_data, s_decrypt, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/rc5_stream_ctrl.sv
// Valid/ready streaming wrapper around the rc5 core with a 2-entry result buffer.
// Define RC5_CBC_EN for CBC chaining through a 32-bit chain register; default build is ECB.
module rc5_stream_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    rc5_stream_ctrl_if.slave st,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    input  logic [31:0]      iv,
    input  logic             iv_load,
    input  logic             key_ready,
    output logic             rc5_start_enc,
    output logic             rc5_start_dec,
    output logic [31:0]      rc5_d_in,
    input  logic [31:0]      rc5_d_out,
    input  logic             rc5_done
);
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    obuf [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             push;
    logic             pop;
    logic             done_ok;
    logic             tmo;
    logic             hold_off;
    logic [DW-1:0]    result;
    logic [DW-1:0]    load_word;

`ifdef RC5_CBC_EN
    logic [DW-1:0] chain;
    logic [DW-1:0] cipher;
    logic          mode;

    // An iv load in IDLE wins over a block acceptance that cycle.
    assign hold_off  = iv_load;
    assign load_word = st.s_decrypt ? st.s_data : (st.s_data ^ chain);
    assign result    = mode ? (rc5_d_out ^ chain) : rc5_d_out;

    // Chain register: iv load, else advance on a completed block (timeouts leave it alone).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain  <= '0;
            cipher <= '0;
            mode   <= 1'b0;
        end else begin
            if (accept) begin
                mode   <= st.s_decrypt;
                cipher <= st.s_data;
            end
            if ((state == IDLE) && iv_load) begin
                chain <= iv;
            end else if (push) begin
                chain <= mode ? cipher : rc5_d_out;
            end
        end
    end
`else
    logic unused_iv;

    assign hold_off  = 1'b0;
    assign load_word = st.s_data;
    assign result    = rc5_d_out;
    assign unused_iv = ^{iv, iv_load};
`endif

    assign st.s_ready = ~rst & (state == IDLE) & key_ready & (count < 2'd2) & ~hold_off;
    assign accept     = st.s_valid & st.s_ready;
    assign pop        = st.m_valid & st.m_ready;
    // A done on the first WAIT cycle belongs to a previous operation.
    assign done_ok    = (state == WAIT) & rc5_done & (cnt != '0);
    assign tmo        = (state == WAIT) & ~done_ok & (cnt == CNT_LAST);
    assign push       = done_ok;

    assign st.m_valid = (count != 2'd0);
    assign st.m_data  = obuf[rd_ptr];
    assign busy       = (state != IDLE) | (count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_ok || tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Start pulses, operand hold, wait counter, result FIFO and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc5_start_enc <= 1'b0;
            rc5_start_dec <= 1'b0;
            rc5_d_in      <= '0;
            cnt           <= '0;
            obuf[0]       <= '0;
            obuf[1]       <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            count         <= 2'd0;
            timeout_err   <= 1'b0;
        end else begin
            rc5_start_enc <= accept & ~st.s_decrypt;
            rc5_start_dec <= accept & st.s_decrypt;
            if (accept) begin
                rc5_d_in <= load_word;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (push) begin
                obuf[wr_ptr] <= result;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end
endmodule
